addr_gen_bp_c: RTL and testbench

- Read-side address generator for the per-timestep h/c memories that the forward-pass h/c write generator fills. Those memories are written in ascending timestep order (addr = t*NUM_CELL + cell).
- This block replays them in reverse timestep order for backpropagation through time. Per cell it issues the current-timestep address and the previous-timestep c address, which the forget-gate derivative needs.
- Sits beside the FSM and datapath in the LSTM top level. It drives rd_addr_h*/rd_addr_c* and the dstate/dgate write strobes timing.

---
 rtl/lstm_pkg.sv | 25 ++
 rtl/addr_gen_bp_c_pause_counter.sv | 33 +++
 rtl/addr_gen_bp_c.sv | 155 +++++++++++++++
 tb/tb_addr_gen_bp_c.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM address generators: FSM encoding and default sizing.
package lstm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int LSTM_ADDR_WIDTH = 12;
   localparam int LSTM_TIMESTEP   = 7;
   localparam int LAYR1_CELL      = 53;
   localparam int LAYR2_CELL      = 8;

   // Width for a down-counter that must hold n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      if (n > 1) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/addr_gen_bp_c_pause_counter.sv
// Loadable down-counter with advance enable and a zero flag; holds at zero.
module pause_counter #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count_r;

   // Count register: clear beats load, load beats decrement.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= {W{1'b0}};
      end else if (clr) begin
         count_r <= {W{1'b0}};
      end else if (load) begin
         count_r <= load_val;
      end else if (dec && (count_r != {W{1'b0}})) begin
         count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/addr_gen_bp_c.sv
// Reverse-timestep read address generator for the h/c memories used by backprop.
// Issues the current and previous-timestep addresses per cell without a multiplier.
module addr_gen_bp_c
   import lstm_pkg::*;
#(
   parameter int ADDR_WIDTH = LSTM_ADDR_WIDTH,
   parameter int TIMESTEP   = LSTM_TIMESTEP,
   parameter int NUM_CELL   = LAYR1_CELL,
   parameter int DELAY      = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  clr,
   input  logic                  en,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic [ADDR_WIDTH-1:0] o_addr_prev,
   output logic                  o_prev_zero,
   output logic [2:0]            o_t,
   output logic                  o_last_cell,
   output logic                  o_valid,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam int CW = cnt_width(DELAY);
   localparam bit HAS_PAUSE = (DELAY > 0);
   localparam logic [ADDR_WIDTH-1:0] A_ZERO  = {ADDR_WIDTH{1'b0}};
   localparam logic [ADDR_WIDTH-1:0] A_NC    = ADDR_WIDTH'(NUM_CELL);
   localparam logic [ADDR_WIDTH-1:0] A_LAST  = ADDR_WIDTH'(NUM_CELL - 1);
   localparam logic [ADDR_WIDTH-1:0] A_BASE0 = ADDR_WIDTH'((TIMESTEP - 1) * NUM_CELL);
   localparam logic [ADDR_WIDTH-1:0] A_PREV0 =
      (TIMESTEP > 1) ? ADDR_WIDTH'((TIMESTEP - 2) * NUM_CELL) : {ADDR_WIDTH{1'b0}};
   localparam logic [2:0]    T_LAST  = 3'(TIMESTEP - 1);
   localparam logic [CW-1:0] P_LOAD  = (DELAY > 0) ? CW'(DELAY - 1) : {CW{1'b0}};

   state_t                  state_r;
   logic [2:0]              t_r;
   logic [ADDR_WIDTH-1:0]   cell_r;
   logic [ADDR_WIDTH-1:0]   base_r;
   logic [ADDR_WIDTH-1:0]   base_prev_r;
   logic                    cell_last_s;
   logic                    t_zero_s;
   logic                    pc_load_s;
   logic                    pc_dec_s;
   logic                    pc_zero_s;

   // End-of-row / first-timestep decode and pause counter controls.
   always_comb begin
      cell_last_s = (cell_r == A_LAST);
      t_zero_s    = (t_r == 3'd0);
      pc_load_s   = 1'b0;
      pc_dec_s    = 1'b0;
      if (HAS_PAUSE && (state_r == ST_RUN) && en && cell_last_s && !t_zero_s) begin
         pc_load_s = 1'b1;
      end else begin
         pc_load_s = 1'b0;
      end
      if ((state_r == ST_PAUSE) && en) begin
         pc_dec_s = 1'b1;
      end else begin
         pc_dec_s = 1'b0;
      end
   end

   pause_counter #(
      .W (CW)
   ) u_pause_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .load     (pc_load_s),
      .load_val (P_LOAD),
      .dec      (pc_dec_s),
      .zero     (pc_zero_s)
   );

   // Replay FSM; stepping to the next-lower timestep subtracts NUM_CELL from both bases.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         t_r         <= 3'd0;
         cell_r      <= A_ZERO;
         base_r      <= A_ZERO;
         base_prev_r <= A_ZERO;
      end else if (clr) begin
         state_r     <= ST_IDLE;
         t_r         <= 3'd0;
         cell_r      <= A_ZERO;
         base_r      <= A_ZERO;
         base_prev_r <= A_ZERO;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  state_r     <= ST_RUN;
                  t_r         <= T_LAST;
                  cell_r      <= A_ZERO;
                  base_r      <= A_BASE0;
                  base_prev_r <= A_PREV0;
               end else begin
                  state_r     <= ST_IDLE;
               end
            end
            ST_RUN: begin
               if (en && !cell_last_s) begin
                  cell_r <= cell_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
               end else if (en && t_zero_s) begin
                  state_r <= ST_DONE;
               end else if (en && HAS_PAUSE) begin
                  state_r <= ST_PAUSE;
               end else if (en) begin
                  t_r         <= t_r - 3'd1;
                  cell_r      <= A_ZERO;
                  base_r      <= base_r - A_NC;
                  base_prev_r <= (t_r == 3'd1) ? A_ZERO : base_prev_r - A_NC;
               end else begin
                  state_r <= ST_RUN;
               end
            end
            ST_PAUSE: begin
               if (en && pc_zero_s) begin
                  state_r     <= ST_RUN;
                  t_r         <= t_r - 3'd1;
                  cell_r      <= A_ZERO;
                  base_r      <= base_r - A_NC;
                  base_prev_r <= (t_r == 3'd1) ? A_ZERO : base_prev_r - A_NC;
               end else begin
                  state_r <= ST_PAUSE;
               end
            end
            ST_DONE: begin
               state_r     <= ST_IDLE;
               t_r         <= 3'd0;
               cell_r      <= A_ZERO;
               base_r      <= A_ZERO;
               base_prev_r <= A_ZERO;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_addr      = base_r + cell_r;
   assign o_addr_prev = t_zero_s ? A_ZERO : (base_prev_r + cell_r);
   assign o_prev_zero = (state_r != ST_IDLE) && t_zero_s;
   assign o_t         = t_r;
   assign o_last_cell = (state_r == ST_RUN) && cell_last_s;
   assign o_valid     = (state_r == ST_RUN) && en;
   assign o_busy      = (state_r != ST_IDLE);
   assign o_done      = (state_r == ST_DONE);

endmodule

// File: tb/tb_addr_gen_bp_c.sv
// Randomized-enable bench for addr_gen_bp_c against a flat address-list reference model.
module tb_addr_gen_bp_c;
   import lstm_pkg::*;

   logic clk = 1'b0;
   logic rst_n, start, clr, en;
   int   sel;
   logic start1, start2;

   logic [11:0] a1_addr, a1_prev, a2_addr, a2_prev, c_addr, c_prev;
   logic [2:0]  a1_t, a2_t, c_t;
   logic a1_pz, a1_last, a1_valid, a1_busy, a1_done;
   logic a2_pz, a2_last, a2_valid, a2_busy, a2_done;
   logic c_pz, c_last, c_valid, c_busy, c_done;

   int n_cmp = 0;
   int n_bad = 0;
   int m_t, m_nc, m_d;

   assign start1 = start & (sel == 0);
   assign start2 = start & (sel == 1);

   always #5 clk = ~clk;

   addr_gen_bp_c dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .clr(clr), .en(en),
      .o_addr(a1_addr), .o_addr_prev(a1_prev), .o_prev_zero(a1_pz), .o_t(a1_t),
      .o_last_cell(a1_last), .o_valid(a1_valid), .o_busy(a1_busy), .o_done(a1_done));

   addr_gen_bp_c #(.ADDR_WIDTH(12), .TIMESTEP(2), .NUM_CELL(LAYR2_CELL), .DELAY(0)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .clr(clr), .en(en),
      .o_addr(a2_addr), .o_addr_prev(a2_prev), .o_prev_zero(a2_pz), .o_t(a2_t),
      .o_last_cell(a2_last), .o_valid(a2_valid), .o_busy(a2_busy), .o_done(a2_done));

   always_comb begin
      if (sel == 1) begin
         c_addr = a2_addr; c_prev = a2_prev; c_t = a2_t; c_pz = a2_pz;
         c_last = a2_last; c_valid = a2_valid; c_busy = a2_busy; c_done = a2_done;
      end else begin
         c_addr = a1_addr; c_prev = a1_prev; c_t = a1_t; c_pz = a1_pz;
         c_last = a1_last; c_valid = a1_valid; c_busy = a1_busy; c_done = a1_done;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_addr"},  32'(c_addr),  0);
      check_val({tag, "_prev"},  32'(c_prev),  0);
      check_val({tag, "_t"},     32'(c_t),     0);
      check_val({tag, "_pz"},    32'(c_pz),    0);
      check_val({tag, "_last"},  32'(c_last),  0);
      check_val({tag, "_valid"}, 32'(c_valid), 0);
      check_val({tag, "_busy"},  32'(c_busy),  0);
      check_val({tag, "_done"},  32'(c_done),  0);
   endtask

   // mode 0: en=1, 1: en toggles (low on odd cycles), 2: random en.
   task automatic run_replay(input int mode, input int abort_at, input int rst_at, input int exp_done);
      int ea[$];
      int ep[$];
      int et[$];
      int total, pos, pause_left, cyc;
      bit fin;
      total = m_t * m_nc;
      for (int t = m_t - 1; t >= 0; t--) begin
         for (int c = 0; c < m_nc; c++) begin
            ea.push_back(t * m_nc + c);
            ep.push_back((t == 0) ? 0 : (t - 1) * m_nc + c);
            et.push_back(t);
         end
      end
      start = 1'b1;
      en    = 1'b1;
      #1;
      check_val("idle_before_start", 32'(c_busy), 0);
      @(negedge clk);
      start = 1'b0;
      pos = 0; pause_left = 0; cyc = 1; fin = 1'b0;
      while (!fin && cyc < 5000) begin
         case (mode)
            0:       en = 1'b1;
            1:       en = (cyc % 2 == 0);
            default: en = 1'($urandom_range(0, 1));
         endcase
         start = (mode == 0 && sel == 0 && (cyc == 50 || cyc == exp_done));
         if (cyc == abort_at) begin
            clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
            #1;
            check_all_zero("after_clr");
            for (int k = 0; k < 30; k++) begin
               @(negedge clk);
               #1;
               check_val("no_done_after_clr", 32'(c_done), 0);
            end
            return;
         end
         if (cyc == rst_at) begin
            rst_n = 1'b0;
            #1;
            check_all_zero("async_rst");
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         #1;
         if (pos == total && pause_left == 0) begin
            check_val("done_pulse", 32'(c_done), 1);
            check_val("done_busy", 32'(c_busy), 1);
            check_val("done_valid", 32'(c_valid), 0);
            if (exp_done > 0) check_val("done_cycle", cyc, exp_done);
            fin = 1'b1;
         end else if (pause_left > 0) begin
            check_val("pause_valid", 32'(c_valid), 0);
            check_val("pause_busy", 32'(c_busy), 1);
            check_val("pause_done", 32'(c_done), 0);
            if (en) pause_left--;
         end else begin
            check_val("run_valid", 32'(c_valid), 32'(en));
            check_val("run_done", 32'(c_done), 0);
            check_val("run_addr", 32'(c_addr), ea[pos]);
            check_val("run_prev", 32'(c_prev), ep[pos]);
            check_val("run_t", 32'(c_t), et[pos]);
            check_val("run_pz", 32'(c_pz), (et[pos] == 0) ? 1 : 0);
            check_val("run_last", 32'(c_last), (pos % m_nc == m_nc - 1) ? 1 : 0);
            if (en) begin
               pos++;
               if (pos % m_nc == 0 && pos < total) pause_left = m_d;
            end
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      if (!fin) begin
         check_val("timeout", 0, 1);
      end else begin
         #1;
         check_val("idle_after_done", 32'(c_busy), 0);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; clr = 1'b0; en = 1'b0; sel = 0;
      m_t = 7; m_nc = 53; m_d = 4;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_all_zero("reset");

      run_replay(0, 0, 0, 396);
      run_replay(0, 0, 0, 396);
      run_replay(1, 0, 0, 791);
      run_replay(2, 0, 0, 0);
      run_replay(2, 0, 0, 0);
      run_replay(0, 100, 0, 0);
      run_replay(0, 0, 0, 396);
      run_replay(0, 0, 200, 0);
      run_replay(0, 0, 0, 396);

      @(negedge clk);
      sel = 1; m_t = 2; m_nc = LAYR2_CELL; m_d = 0;
      #1;
      run_replay(0, 0, 0, 17);
      run_replay(2, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
